// File: rtl/mdu_pkg.sv
// Op codes, FSM state type and decode helpers shared by the multiply/divide unit and the hazard unit.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops to the decode.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_mode_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True when this EX instruction launches a multi-cycle operation.
  function automatic logic is_md_start(input logic md_start, input logic [3:0] op);
    return md_start && (is_mul_op(op) || is_div_op(op));
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32/32 signed/unsigned divider: quotient truncates toward zero,
// remainder takes the dividend's sign; divide-by-zero gives quot=all ones, rem=dividend.
module mdu_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;

  assign neg_a = is_signed & dividend[31];
  assign neg_b = is_signed & divisor[31];
  assign mag_a = neg_a ? -dividend : dividend;
  assign mag_b = neg_b ? -divisor  : divisor;
  assign mag_q = mag_a / mag_b;
  assign mag_r = mag_a % mag_b;

  // 0x8000_0000 / -1 falls out of the magnitude path as 0x8000_0000 rem 0.
  always_comb begin
    if (divisor == 32'd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = dividend;
    end else begin
      quot = (neg_a ^ neg_b) ? -mag_q : mag_q;
      rem  = neg_a ? -mag_r : mag_r;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency MULT/DIV plus MFHI/MFLO/MTHI/MTLO.
// Define MDU_MADD_EN to build the MADD/MADDU/MSUB/MSUBU accumulate path.
module ex_muldiv
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_err,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  md_state_t   state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        op_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic [31:0] quot;
  logic [31:0] rem;
`ifdef MDU_MADD_EN
  acc_mode_t   acc_mode;
`endif

  always_comb begin
    // NOTE: default assignment first so no path leaves op_signed unassigned (no latch).
    op_signed = 1'b0;
    case (md_op)
      MD_MULT, MD_DIV: op_signed = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MSUB: op_signed = 1'b1;
`endif
      default: ;
    endcase
  end

  // Sign/zero extend to 64 bits; the low 64 bits of the product are then exact for both.
  assign a_ext   = op_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
  assign b_ext   = op_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
  assign product = a_ext * b_ext;

  mdu_divider u_divider (
    .dividend  (rs_val),
    .divisor   (rt_val),
    .is_signed (op_signed),
    .quot      (quot),
    .rem       (rem)
  );

  assign busy = (state == ST_RUN);

  always_comb begin
    md_out = 32'd0;
    case (md_op)
      MD_MFHI: md_out = hi;
      MD_MFLO: md_out = lo;
      default: ;
    endcase
  end

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      md_err  <= 1'b0;
`ifdef MDU_MADD_EN
      acc_mode <= ACC_NONE;
`endif
    end else begin
      md_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (md_start) begin
            if (is_mul_op(md_op)) begin
              state              <= ST_RUN;
              cnt                <= MUL_N;
              {pend_hi, pend_lo} <= product;
            end else if (is_div_op(md_op)) begin
              state              <= ST_RUN;
              cnt                <= DIV_N;
              {pend_hi, pend_lo} <= {rem, quot};
            end else if (md_op == MD_MTHI) begin
              hi <= rs_val;
            end else if (md_op == MD_MTLO) begin
              lo <= rs_val;
            end
`ifdef MDU_MADD_EN
            case (md_op)
              MD_MADD, MD_MADDU: acc_mode <= ACC_ADD;
              MD_MSUB, MD_MSUBU: acc_mode <= ACC_SUB;
              default:           acc_mode <= ACC_NONE;
            endcase
`endif
          end
        end
        ST_RUN: begin
          // A start here is a hazard-unit bug: flag it and leave everything else alone.
          if (md_start) md_err <= 1'b1;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_IDLE;
`ifdef MDU_MADD_EN
            case (acc_mode)
              ACC_ADD: {hi, lo} <= {hi, lo} + {pend_hi, pend_lo};
              ACC_SUB: {hi, lo} <= {hi, lo} - {pend_hi, pend_lo};
              default: {hi, lo} <= {pend_hi, pend_lo};
            endcase
`else
            {hi, lo} <= {pend_hi, pend_lo};
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, hand-written protocol/reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_ex_muldiv;
  import mdu_pkg::*;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        md_err;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  ex_muldiv #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .md_err   (md_err),
    .hi       (hi),
    .lo       (lo),
    .md_out   (md_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Present one op for a single edge; returns at the negedge after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    md_start = 1'b0; md_op = MD_NONE;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic mf_check(input logic [3:0] op, input logic [31:0] exp, input string name);
    @(negedge clk);
    md_start = 1'b1; md_op = op;
    #1 check(name, md_out, exp);
    @(negedge clk);
    md_start = 1'b0; md_op = MD_NONE;
    check({name, "_nobusy"}, busy, 1'b0);
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          cyc;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [63:0] r;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_N};
    vecs[1] = '{MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        DIV_N};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    vecs[3] = '{MD_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, DIV_N};
    vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, DIV_N};
    vecs[5] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_N};
    vecs[6] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, DIV_N};
    vecs[7] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, DIV_N};
    vecs[8] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        MUL_N};

    reset = 1'b0; md_start = 1'b0; md_op = MD_NONE; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_err", md_err, 1'b0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(cyc);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cycles));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      model_hi = vecs[i].exp_hi;
      model_lo = vecs[i].exp_lo;
    end

    issue(MD_MTHI, 32'h1234, 32'd0);
    check("mthi_busy", busy, 1'b0);
    mf_check(MD_MFHI, 32'h1234, "mfhi");
    issue(MD_MTLO, 32'hCAFE_0001, 32'd0);
    check("mtlo_busy", busy, 1'b0);
    mf_check(MD_MFLO, 32'hCAFE_0001, "mflo");

    // Protocol violation at busy cycle 2: pulse md_err, keep the first result.
    issue(MD_MULT, 32'd6, 32'd7);
    @(negedge clk);
    md_start = 1'b1; md_op = MD_DIVU; rs_val = 32'd99; rt_val = 32'd3;
    @(negedge clk);
    md_start = 1'b0; md_op = MD_NONE;
    check("err_pulse", md_err, 1'b1);
    @(negedge clk);
    check("err_clear", md_err, 1'b0);
    wait_done(cyc);
    check("err_remaining_cycles", 64'(cyc), 64'(MUL_N - 3));
    check("err_hi", hi, 32'd0);
    check("err_lo", lo, 32'd42);

    // Reset asserted at busy cycle 3 clears state immediately and drops the pending result.
    issue(MD_MULT, 32'hFFFF_FFFF, 32'd5);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (MUL_N + 2) @(negedge clk);
    check("rst_discard_lo", lo, 32'd0);
    check("rst_discard_busy", busy, 1'b0);
    model_hi = 32'd0;
    model_lo = 32'd0;

    issue(MD_MTLO, 32'd10, 32'd0);
    issue(MD_MTHI, 32'd0, 32'd0);
    issue(MD_MADDU, 32'd3, 32'd4);
    wait_done(cyc);
`ifdef MDU_MADD_EN
    check("maddu_cycles", 64'(cyc), 64'(MUL_N));
    check("maddu_lo", lo, 32'd22);
    check("maddu_hi", hi, 32'd0);
    issue(MD_MSUB, 32'd1, 32'd23);
    wait_done(cyc);
    check("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    model_hi = 32'hFFFF_FFFF;
    model_lo = 32'hFFFF_FFFF;
`else
    check("maddu_noop_cycles", 64'(cyc), 64'd0);
    check("maddu_noop_lo", lo, 32'd10);
    issue(MD_MSUB, 32'd1, 32'd23);
    check("msub_noop_busy", busy, 1'b0);
    check("msub_noop_lo", lo, 32'd10);
    model_hi = 32'd0;
    model_lo = 32'd10;
`endif

    issue(4'd15, 32'd1, 32'd1);
    check("undef_op_busy", busy, 1'b0);
    check("undef_op_err", md_err, 1'b0);

    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(1, 8));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 15))
        0, 1: b = 32'd0;
        2:    begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3, 4: begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
        5:    b = 32'(-$urandom_range(1, 9));
        default: ;
      endcase
      case (op)
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
          issue(op, a, b);
          wait_done(cyc);
          r = ref_md(op, a, b);
          check($sformatf("rand%0d_op%0d_cycles", n, op), 64'(cyc),
                64'((op == MD_DIV || op == MD_DIVU) ? DIV_N : MUL_N));
          check($sformatf("rand%0d_op%0d_hilo a=%h b=%h", n, op, a, b), {hi, lo}, r);
          model_hi = r[63:32];
          model_lo = r[31:0];
        end
        MD_MTHI: begin
          issue(op, a, b);
          model_hi = a;
          check($sformatf("rand%0d_mthi", n), {31'd0, busy, hi}, {32'd0, model_hi});
        end
        MD_MTLO: begin
          issue(op, a, b);
          model_lo = a;
          check($sformatf("rand%0d_mtlo", n), {31'd0, busy, lo}, {32'd0, model_lo});
        end
        MD_MFHI: mf_check(op, model_hi, $sformatf("rand%0d_mfhi", n));
        default: mf_check(MD_MFLO, model_lo, $sformatf("rand%0d_mflo", n));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
